// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write-port arbiter for one shared datapath register
// Supports locked bursts of up to MAX_BURST writes and a clear request that overrides all other traffic.
module reg_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    input  logic                    clr,
    output logic [N_REQ-1:0]        gnt,
    output logic                    reg_write,
    output logic [DATA_W-1:0]       reg_inp,
    output logic                    reg_clear,
    output logic                    busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gidx;
    logic [CNT_W-1:0]   burst_cnt;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_next;
    logic               hold_lock;

    // First asserted request at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign win_next  = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    assign hold_lock = ((state == GRANT) || (state == LOCK)) && req[gidx] && lock[gidx]
                       && (burst_cnt < CNT_W'(MAX_BURST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            burst_cnt <= '0;
            gnt       <= '0;
            reg_write <= 1'b0;
            reg_inp   <= '0;
            reg_clear <= 1'b0;
            busy      <= 1'b0;
        end else if (clr) begin
            // Clear wins outright; pending requests simply wait and the pointer is untouched.
            state     <= CLEAR;
            gnt       <= '0;
            reg_write <= 1'b0;
            reg_clear <= 1'b1;
            burst_cnt <= '0;
            busy      <= 1'b1;
        end else begin
            reg_clear <= 1'b0;
            if (hold_lock) begin
                state     <= LOCK;
                reg_write <= 1'b1;
                reg_inp   <= wdata[int'(gidx)*DATA_W +: DATA_W];
                burst_cnt <= burst_cnt + CNT_W'(1);
                busy      <= 1'b1;
            end else if (win_found) begin
                state     <= GRANT;
                gnt       <= N_REQ'(1) << win_idx;
                reg_write <= 1'b1;
                reg_inp   <= wdata[int'(win_idx)*DATA_W +: DATA_W];
                ptr       <= win_next;
                gidx      <= win_idx;
                burst_cnt <= CNT_W'(1);
                busy      <= 1'b1;
            end else begin
                state     <= IDLE;
                gnt       <= '0;
                reg_write <= 1'b0;
                burst_cnt <= '0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the write port of one 32-bit datapath register among N_REQ requesters.
- Round-robin arbitration with an optional locked burst mode and a top-priority clear request.
- Outputs drive the register directly: reg_write to its write enable, reg_inp to its data input, reg_clear to its synchronous clear.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive grants one requester may hold via lock (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester write request, level.
- lock  input  N_REQ  per-requester burst-hold request; only meaningful while that requester is granted.
- wdata  input  N_REQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W].
- clr  input  1  clear request for the shared register.
- gnt  output  N_REQ  registered one-hot grant (all-zero when idle).
- reg_write  output  1  registered write enable to the register.
- reg_inp  output  DATA_W  registered write data to the register.
- reg_clear  output  1  registered clear pulse to the register.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): gnt=0, reg_write=0, reg_clear=0, reg_inp=0, busy=0, state=IDLE, rr pointer=0 (requester 0 highest priority), burst count=0.
- All outputs are registered, so combinational inputs never reach outputs in the same cycle.
- States: IDLE, GRANT, LOCK, CLEAR.
- Arbitration at each rising edge when the next state is GRANT:
  - Winner is the first i with req[i]=1, searching from ptr, ptr+1, ... modulo N_REQ.
  - gnt<=onehot(winner), reg_write<=1, reg_inp<=wdata[winner], ptr<=(winner+1) mod N_REQ, burst count<=1.
- Latency: a req sampled at edge k produces gnt and reg_write high during cycle k..k+1. The register captures reg_inp at edge k+1.
- gnt is the acknowledge. A requester must drop req, or present new data, in the cycle after seeing gnt.
- Transitions (evaluated at each edge; clr overrides all):
  - any state, clr=1 -> CLEAR: reg_clear<=1, gnt<=0, reg_write<=0. Pending requests wait. ptr unchanged. An active lock is aborted.
  - IDLE/CLEAR, clr=0, any req -> GRANT (arbitrate).
  - IDLE/CLEAR, clr=0, no req -> IDLE: all strobes 0.
  - GRANT/LOCK, granted requester g has req[g]=1, lock[g]=1, and burst count < MAX_BURST -> LOCK:
    - gnt stays on g, reg_write<=1, reg_inp<=wdata[g], burst count+1.
    - ptr stays (g+1) mod N_REQ.
  - GRANT/LOCK, otherwise -> arbitrate among current req. If a request wins -> GRANT; if none -> IDLE.
- Released requester: g is excluded only by pointer order. After MAX_BURST forced release, g may win again only if no other requester is asserting.
- reg_clear is a single-cycle pulse per clr cycle. Holding clr high for n cycles holds reg_clear high for n cycles, with no writes during them.
- reg_inp holds its last value when reg_write=0. It is not zeroed.
- Reset during GRANT/LOCK/CLEAR immediately zeroes all outputs. No partial write is issued after reset is released.
- ptr arithmetic wraps: N_REQ-1 -> 0.

Test Plan:
- Reset release, req=0, clr=0 -> gnt=0, reg_write=0, reg_clear=0, reg_inp=0, busy=0 held for 10 cycles.
- req=4'b0001, wdata[0]=32'hDEADBEEF for one cycle -> next cycle gnt=4'b0001, reg_write=1, reg_inp=32'hDEADBEEF, busy=1; one cycle later all 0, busy=0.
- req=4'b1111 held for 8 cycles with distinct data 32'h10/20/30/40 -> grants in order 0,1,2,3,0,1,2,3 on consecutive cycles, reg_inp matching each grant, reg_write high throughout.
- req=4'b0011 and lock=4'b0001 held, MAX_BURST=4 -> gnt=0001 for 4 cycles, then 0010 for 1 cycle, then 0001 again.
- Mid-lock (2nd burst cycle) with clr=1 for one cycle -> the next cycle has reg_clear=1, gnt=0, reg_write=0; the following cycle re-arbitrates with ptr=1, so gnt=4'b0010 when req=4'b0011.
- reset driven low while in LOCK with reg_write=1 -> outputs zero immediately, without waiting for a clk edge; after reset rises with req=4'b0100, the first grant is 4'b0100.
